// File: rtl/poly_midi_player.sv
// poly_midi_player: MIDI note parser, NUM_VOICES square oscillators, serial mixer.
// Optional MIDI_RUNNING_STATUS_EN: data bytes reuse the last accepted channel status.
module poly_midi_player #(
  parameter int NUM_VOICES   = 4,
  parameter int MIDI_CHANNEL = 0,
  parameter int PHASE_W      = 24
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        new_byte_ready,
  input  logic [7:0]  new_byte,
  input  logic        new_frame,
  output logic [15:0] sample_out,
  output logic        new_sample_generated
);

`ifdef MIDI_RUNNING_STATUS_EN
  localparam bit RS_EN = 1'b1;
`else
  localparam bit RS_EN = 1'b0;
`endif

  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = 16 + $clog2(NUM_VOICES);
  localparam logic [VW-1:0] LAST = VW'(NUM_VOICES - 1);
  localparam logic signed [ACC_W-1:0] MAXV = 32767;
  localparam logic signed [ACC_W-1:0] MINV = -32768;

  typedef enum logic [1:0] {WAIT_STATUS, DATA1, DATA2, SKIP} p_state_t;
  typedef enum logic [1:0] {IDLE, MIX, OUT} m_state_t;

  // Increments for MIDI notes 120..131 at 48 kHz, 24-bit phase
  function automatic logic [23:0] tbl(input logic [3:0] s);
    case (s)
      4'd0:    tbl = 24'd2926227;
      4'd1:    tbl = 24'd3100235;
      4'd2:    tbl = 24'd3284585;
      4'd3:    tbl = 24'd3479896;
      4'd4:    tbl = 24'd3686822;
      4'd5:    tbl = 24'd3906052;
      4'd6:    tbl = 24'd4138318;
      4'd7:    tbl = 24'd4384395;
      4'd8:    tbl = 24'd4645105;
      4'd9:    tbl = 24'd4921317;
      4'd10:   tbl = 24'd5213953;
      4'd11:   tbl = 24'd5523991;
      default: tbl = 24'd0;
    endcase
  endfunction

  logic [NUM_VOICES-1:0] v_act;
  logic [6:0]            v_note  [NUM_VOICES];
  logic [6:0]            v_vel   [NUM_VOICES];
  logic [PHASE_W-1:0]    v_phase [NUM_VOICES];
  logic [VW-1:0]         steal_ptr;

  p_state_t   p_state, p_next;
  logic       cmd_on, cmd_nx;
  logic [6:0] note_r, note_nx;
  logic       rs_valid, rs_nx;
  logic       ev_on, ev_off;
  logic       is_status, accept;

  assign is_status = new_byte[7];
  assign accept    = (new_byte[3:0] == 4'(MIDI_CHANNEL)) &&
                     (new_byte[6:4] == 3'b001 || new_byte[6:4] == 3'b000);

  always_comb begin
    p_next  = p_state;
    cmd_nx  = cmd_on;
    note_nx = note_r;
    rs_nx   = rs_valid;
    ev_on   = 1'b0;
    ev_off  = 1'b0;
    if (new_byte_ready) begin
      if (is_status) begin
        if (accept) begin
          p_next = DATA1;
          cmd_nx = new_byte[4];
          rs_nx  = 1'b1;
        end else begin
          p_next = SKIP;
          rs_nx  = 1'b0;
        end
      end else begin
        unique case (p_state)
          WAIT_STATUS: begin
            if (rs_valid) begin
              note_nx = new_byte[6:0];
              p_next  = DATA2;
            end
          end
          DATA1: begin
            note_nx = new_byte[6:0];
            p_next  = DATA2;
          end
          DATA2: begin
            ev_on  = cmd_on && (new_byte[6:0] != 7'd0);
            ev_off = !ev_on;
            p_next = WAIT_STATUS;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      p_state  <= WAIT_STATUS;
      cmd_on   <= 1'b0;
      note_r   <= '0;
      rs_valid <= 1'b0;
    end else begin
      p_state  <= p_next;
      cmd_on   <= cmd_nx;
      note_r   <= note_nx;
      rs_valid <= RS_EN && rs_nx;
    end
  end

  logic          hit, free, do_steal;
  logic [VW-1:0] hit_idx, free_idx, sel_idx;

  // Downward scan leaves the lowest matching index
  always_comb begin
    hit      = 1'b0;
    free     = 1'b0;
    hit_idx  = '0;
    free_idx = '0;
    for (int k = NUM_VOICES - 1; k >= 0; k--) begin
      if (v_act[k] && v_note[k] == note_r) begin
        hit     = 1'b1;
        hit_idx = VW'(k);
      end
      if (!v_act[k]) begin
        free     = 1'b1;
        free_idx = VW'(k);
      end
    end
    do_steal = !hit && !free;
    sel_idx  = hit ? hit_idx : (free ? free_idx : steal_ptr);
  end

  m_state_t   m_state, m_next;
  logic       nf_q, frame_rise;
  logic [VW-1:0] vidx;
  logic signed [ACC_W-1:0] acc, amp, contrib;
  logic [6:0]  cur_note;
  logic [3:0]  oct, semi;
  logic [PHASE_W-1:0] inc;
  logic [15:0] sat;

  assign frame_rise = new_frame && !nf_q;
  assign cur_note   = v_note[vidx];
  assign oct        = 4'(cur_note / 7'd12);
  assign semi       = 4'(cur_note % 7'd12);
  assign inc        = PHASE_W'(tbl(semi) >> (4'd10 - oct));
  assign amp        = ACC_W'({v_vel[vidx], 8'h00});

  always_comb begin
    contrib = '0;
    if (v_act[vidx])
      contrib = v_phase[vidx][PHASE_W-1] ? -amp : amp;
  end

  always_comb begin
    sat = acc[15:0];
    if (acc > MAXV)
      sat = 16'h7fff;
    else if (acc < MINV)
      sat = 16'h8000;
  end

  always_comb begin
    m_next = m_state;
    unique case (m_state)
      IDLE:    if (frame_rise) m_next = MIX;
      MIX:     if (vidx == LAST) m_next = OUT;
      OUT:     m_next = IDLE;
      default: m_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_state              <= IDLE;
      nf_q                 <= 1'b0;
      vidx                 <= '0;
      acc                  <= '0;
      sample_out           <= '0;
      new_sample_generated <= 1'b0;
    end else begin
      m_state              <= m_next;
      nf_q                 <= new_frame;
      new_sample_generated <= (m_state == OUT);
      unique case (m_state)
        IDLE: begin
          vidx <= '0;
          acc  <= '0;
        end
        MIX: begin
          acc  <= acc + contrib;
          vidx <= vidx + 1'b1;
        end
        OUT:     sample_out <= sat;
        default: ;
      endcase
    end
  end

  // Parser writes come after the mixer phase step so they win on a clash
  always_ff @(posedge clk) begin
    if (reset) begin
      v_act     <= '0;
      steal_ptr <= '0;
      for (int k = 0; k < NUM_VOICES; k++) begin
        v_note[k]  <= '0;
        v_vel[k]   <= '0;
        v_phase[k] <= '0;
      end
    end else begin
      if (m_state == MIX && v_act[vidx])
        v_phase[vidx] <= v_phase[vidx] + inc;
      if (ev_on) begin
        v_act[sel_idx]   <= 1'b1;
        v_note[sel_idx]  <= note_r;
        v_vel[sel_idx]   <= new_byte[6:0];
        v_phase[sel_idx] <= '0;
        if (do_steal)
          steal_ptr <= (steal_ptr == LAST) ? '0 : steal_ptr + 1'b1;
      end
      if (ev_off) begin
        for (int k = 0; k < NUM_VOICES; k++)
          if (v_note[k] == note_r) v_act[k] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_poly_midi_player.sv
// tb_poly_midi_player: directed MIDI byte sequences and frame requests
// against hand-computed mixed sample values.
module tb_poly_midi_player;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_byte_ready = 1'b0;
  logic [7:0]  new_byte = 8'h00;
  logic        new_frame = 1'b0;
  logic [15:0] sample_out;
  logic        new_sample_generated;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  poly_midi_player dut (
    .clk                  (clk),
    .reset                (reset),
    .new_byte_ready       (new_byte_ready),
    .new_byte             (new_byte),
    .new_frame            (new_frame),
    .sample_out           (sample_out),
    .new_sample_generated (new_sample_generated)
  );

  task automatic chk(input string tag, input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    new_byte       = b;
    new_byte_ready = 1'b1;
    @(negedge clk);
    new_byte_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic frame(input string tag, input int exp);
    int n;
    logic got;
    @(negedge clk);
    new_frame = 1'b1;
    @(posedge clk);
    #1 new_frame = 1'b0;
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      got = new_sample_generated;
    end
    chk({tag, "_lat"}, n, 5);
    chk(tag, $signed(sample_out), exp);
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, new_sample_generated, 0);
  endtask

  initial begin
    int exp;
    int cnt;

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_sample", $signed(sample_out), 0);
    chk("rst_strobe", new_sample_generated, 0);
    frame("rst_frame", 0);

    // note 69: inc 153791, MSB set for frames 55..109
    send(8'h90); send(8'd69); send(8'd127);
    for (int n = 0; n <= 110; n++) begin
      exp = (n < 55 || n >= 110) ? 32512 : -32512;
      frame($sformatf("single_%0d", n), exp);
    end

    // notes 60 (inc 91444) and 64 (inc 115213)
    do_reset();
    send(8'h90); send(8'd60); send(8'd127);
    send(8'h90); send(8'd64); send(8'd127);
    for (int n = 0; n <= 150; n++) begin
      if (n <= 72)       exp = 32767;
      else if (n <= 91)  exp = 0;
      else if (n <= 145) exp = -32768;
      else               exp = 0;
      frame($sformatf("dual_%0d", n), exp);
    end

    do_reset();
    send(8'h90); send(8'd60); send(8'd127);
    send(8'h90); send(8'd64); send(8'd127);
    send(8'h80); send(8'd64); send(8'd0);
    frame("off_8x", 32512);
    send(8'h90); send(8'd60); send(8'd0);
    frame("off_vel0", 0);

    // low notes keep phase MSB clear for the whole section
    do_reset();
    send(8'h90); send(8'd0); send(8'd1);
    send(8'h90); send(8'd1); send(8'd2);
    send(8'h90); send(8'd2); send(8'd4);
    send(8'h90); send(8'd3); send(8'd8);
    frame("steal_four", 3840);
    send(8'h90); send(8'd4); send(8'd16);
    frame("steal_v0", 7680);
    send(8'h80); send(8'd0); send(8'd0);
    frame("steal_gone", 7680);
    send(8'h91); send(8'd5); send(8'd64);
    send(8'd5); send(8'd64);
    frame("wrong_chan", 7680);
    send(8'h90); send(8'd5); send(8'd32);
    frame("steal_v1", 15360);
    send(8'h90); send(8'd3); send(8'd64);
    frame("retrigger", 29696);
    send(8'h80); send(8'd4); send(8'd0);
    frame("steal_off", 25600);

    do_reset();
    send(8'h90); send(8'd60); send(8'd100);
    send(8'd64); send(8'd100);
`ifdef MIDI_RUNNING_STATUS_EN
    frame("running", 32767);
`else
    frame("running", 25600);
`endif

    // second rising edge lands in MIX and is dropped
    do_reset();
    @(negedge clk); new_frame = 1'b1;
    @(negedge clk); new_frame = 1'b0;
    @(negedge clk); new_frame = 1'b1;
    @(negedge clk); new_frame = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (new_sample_generated) cnt++;
    end
    chk("b2b_strobes", cnt, 1);

    send(8'h90); send(8'd69); send(8'd127);
    @(negedge clk); new_frame = 1'b1;
    @(negedge clk); new_frame = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (new_sample_generated) cnt++;
    end
    chk("midmix_strobes", cnt, 0);
    chk("midmix_sample", $signed(sample_out), 0);
    frame("post_reset", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
